// File: rtl/rx_cgs_fsm.sv
// rx_cgs_fsm: JESD204-style receiver code group synchronization state machine.
// Watches decoded characters for four consecutive /K/ (K28.5), waits for an
// LMFC boundary in CS_CHECK to release SYNC~, then starts the ILA on the first
// /R/ (K28.0) and enters CS_DATA. In CS_CHECK and CS_DATA, a leaky error counter
// sends the link back to CS_INIT after three errors that are not cleared by
// runs of four good characters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lmfc_clk            one-cycle pulse at each local multiframe boundary
//   i_valid             qualifies i_char / i_is_k / i_disp_err / i_nit_err
//   i_char, i_is_k      decoded octet and control flag
//   i_disp_err          running-disparity error
//   i_nit_err           not-in-table error
//   i_resync            level-sensitive re-initialization request
//   o_sync_n            SYNC~ (0 requests code group synchronization)
//   o_state             0 CS_INIT, 1 CS_CHECK, 2 CS_DATA
//   o_ila_start         one-cycle pulse on the first /R/
//   o_cgs_done          high while in CS_DATA
module rx_cgs_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lmfc_clk,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  input  logic       i_is_k,
  input  logic       i_disp_err,
  input  logic       i_nit_err,
  input  logic       i_resync,
  output logic       o_sync_n,
  output logic [1:0] o_state,
  output logic       o_ila_start,
  output logic       o_cgs_done
);

  localparam int unsigned KCW = 3;
  localparam int unsigned ECW = 2;
  localparam int unsigned GCW = 3;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [KCW-1:0] k_cnt_q, k_cnt_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;
  logic [GCW-1:0] good_cnt_q, good_cnt_d;
  logic           sync_n_q, sync_n_d;
  logic           ila_q, ila_d;
  logic           done_q, done_d;

  // Character classification
  logic is_bad, is_kc, is_rc;
  assign is_bad = i_disp_err | i_nit_err;
  assign is_kc  = ~is_bad & i_is_k & (i_char == K28_5);
  assign is_rc  = ~is_bad & i_is_k & (i_char == K28_0);

  // Per-character verdict in CS_CHECK / CS_DATA
  logic ch_good, ch_err;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    k_cnt_d    = k_cnt_q;
    err_cnt_d  = err_cnt_q;
    good_cnt_d = good_cnt_q;
    sync_n_d   = sync_n_q;
    ila_d      = 1'b0;
    ch_good    = 1'b0;
    ch_err     = 1'b0;

    if (i_resync) begin
      state_d    = CS_INIT;
      k_cnt_d    = '0;
      err_cnt_d  = '0;
      good_cnt_d = '0;
      sync_n_d   = 1'b0;
    end else begin
      case (state_q)
        CS_INIT: begin
          sync_n_d   = 1'b0;
          err_cnt_d  = '0;
          good_cnt_d = '0;
          if (i_valid) begin
            if (is_kc) begin
              if (k_cnt_q == KCW'(3)) begin
                state_d = CS_CHECK;
                k_cnt_d = '0;
              end else begin
                k_cnt_d = k_cnt_q + KCW'(1);
              end
            end else begin
              k_cnt_d = '0;
            end
          end
        end

        CS_CHECK: begin
          // state_q is only CS_CHECK from the cycle after entry, so a pulse
          // coincident with the entering transition is not seen here.
          if (lmfc_clk) sync_n_d = 1'b1;
          if (i_valid) begin
            if (sync_n_q && is_rc) begin
              ch_good = 1'b1;
              state_d = CS_DATA;
              ila_d   = 1'b1;
            end else begin
              ch_good = is_kc;
            end
            ch_err = ~ch_good;
          end
        end

        CS_DATA: begin
          sync_n_d = 1'b1;
          if (i_valid) begin
            ch_good = ~is_bad;
            ch_err  = is_bad;
          end
        end

        default: begin
          state_d    = CS_INIT;
          k_cnt_d    = '0;
          err_cnt_d  = '0;
          good_cnt_d = '0;
          sync_n_d   = 1'b0;
        end
      endcase

      // Leaky error counter: third uncleared error drops the link
      if (ch_err) begin
        if (err_cnt_q == ECW'(2)) begin
          state_d    = CS_INIT;
          sync_n_d   = 1'b0;
          ila_d      = 1'b0;
          k_cnt_d    = '0;
          err_cnt_d  = '0;
          good_cnt_d = '0;
        end else begin
          err_cnt_d  = err_cnt_q + ECW'(1);
          good_cnt_d = '0;
        end
      end else if (ch_good) begin
        if (good_cnt_q == GCW'(3)) begin
          err_cnt_d  = '0;
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_cnt_q + GCW'(1);
        end
      end
    end

    done_d = (state_d == CS_DATA);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CS_INIT;
      k_cnt_q    <= '0;
      err_cnt_q  <= '0;
      good_cnt_q <= '0;
      sync_n_q   <= 1'b0;
      ila_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      err_cnt_q  <= err_cnt_d;
      good_cnt_q <= good_cnt_d;
      sync_n_q   <= sync_n_d;
      ila_q      <= ila_d;
      done_q     <= done_d;
    end
  end

  assign o_state     = 2'(state_q);
  assign o_sync_n    = sync_n_q;
  assign o_ila_start = ila_q;
  assign o_cgs_done  = done_q;

endmodule

// File: tb/tb_rx_cgs_fsm.sv
// tb_rx_cgs_fsm: directed self-checking bench for rx_cgs_fsm.
module tb_rx_cgs_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lmfc_clk;
  logic       i_valid;
  logic [7:0] i_char;
  logic       i_is_k;
  logic       i_disp_err;
  logic       i_nit_err;
  logic       i_resync;
  logic       o_sync_n;
  logic [1:0] o_state;
  logic       o_ila_start;
  logic       o_cgs_done;

  int n_tests = 0;
  int n_fail  = 0;

  rx_cgs_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lmfc_clk    (lmfc_clk),
    .i_valid     (i_valid),
    .i_char      (i_char),
    .i_is_k      (i_is_k),
    .i_disp_err  (i_disp_err),
    .i_nit_err   (i_nit_err),
    .i_resync    (i_resync),
    .o_sync_n    (o_sync_n),
    .o_state     (o_state),
    .o_ila_start (o_ila_start),
    .o_cgs_done  (o_cgs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of inputs, then return to idle
  task automatic put(input logic v, input logic [7:0] c, input logic k,
                     input logic de, input logic lm);
    i_valid    = v;
    i_char     = c;
    i_is_k     = k;
    i_disp_err = de;
    lmfc_clk   = lm;
    tick();
    i_valid    = 1'b0;
    i_char     = 8'h00;
    i_is_k     = 1'b0;
    i_disp_err = 1'b0;
    lmfc_clk   = 1'b0;
  endtask

  task automatic put_k();
    put(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic put_d(input logic de);
    put(1'b1, 8'h55, 1'b0, de, 1'b0);
  endtask

  // From CS_INIT: four /K/, LMFC release, then /R/
  task automatic to_data();
    for (int i = 0; i < 4; i++) put_k();
    put(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    put(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; lmfc_clk = 1'b0; i_valid = 1'b0; i_char = 8'h00;
    i_is_k = 1'b0; i_disp_err = 1'b0; i_nit_err = 1'b0; i_resync = 1'b0;
    #12;
    check("rst_state",  32'(o_state), 32'd0);
    check("rst_sync_n", 32'(o_sync_n), 32'd0);
    check("rst_ila",    32'(o_ila_start), 32'd0);
    check("rst_done",   32'(o_cgs_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Four K, the fourth with a coincident LMFC that must not count
    for (int i = 0; i < 3; i++) put_k();
    check("k3_state", 32'(o_state), 32'd0);
    put(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
    check("k4_state", 32'(o_state), 32'd1);
    check("k4_sync_n", 32'(o_sync_n), 32'd0);
    for (int i = 0; i < 10; i++) put(1'b0, 8'h1C, 1'b1, 1'b1, 1'b0);
    check("gap_state", 32'(o_state), 32'd1);
    check("gap_sync_n", 32'(o_sync_n), 32'd0);
    put(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("lmfc_sync_n", 32'(o_sync_n), 32'd1);

    // ILA start on /R/
    put_k();
    check("chk_k_state", 32'(o_state), 32'd1);
    check("chk_k_ila", 32'(o_ila_start), 32'd0);
    put(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    check("r_state", 32'(o_state), 32'd2);
    check("r_ila", 32'(o_ila_start), 32'd1);
    check("r_done", 32'(o_cgs_done), 32'd1);
    tick();
    check("ila_pulse_end", 32'(o_ila_start), 32'd0);
    check("data_state", 32'(o_state), 32'd2);

    // Errors separated by 2 good chars drop the link
    put_d(1'b1); put_d(1'b0); put_d(1'b0);
    put_d(1'b1); put_d(1'b0); put_d(1'b0);
    check("err2_state", 32'(o_state), 32'd2);
    put_d(1'b1);
    check("err3_state", 32'(o_state), 32'd0);
    check("err3_sync_n", 32'(o_sync_n), 32'd0);
    check("err3_done", 32'(o_cgs_done), 32'd0);

    // Errors separated by 4 good chars (with idle gaps) are forgiven
    to_data();
    check("redata_state", 32'(o_state), 32'd2);
    for (int e = 0; e < 3; e++) begin
      put_d(1'b1);
      for (int g = 0; g < 4; g++) begin
        put_d(1'b0);
        put(1'b0, 8'hBC, 1'b1, 1'b1, 1'b1);
      end
    end
    check("leaky_state", 32'(o_state), 32'd2);
    check("leaky_done", 32'(o_cgs_done), 32'd1);
    check("leaky_sync_n", 32'(o_sync_n), 32'd1);

    // Resync pulse in CS_DATA, then held high across K chars
    i_resync = 1'b1;
    put_d(1'b0);
    check("resync_state", 32'(o_state), 32'd0);
    check("resync_sync_n", 32'(o_sync_n), 32'd0);
    check("resync_done", 32'(o_cgs_done), 32'd0);
    for (int i = 0; i < 4; i++) put_k();
    check("resync_hold_state", 32'(o_state), 32'd0);
    i_resync = 1'b0;
    for (int i = 0; i < 3; i++) put_k();
    check("post_resync_k3", 32'(o_state), 32'd0);
    put_k();
    check("post_resync_k4", 32'(o_state), 32'd1);

    // Data char breaks the K run; invalid cycles do not
    i_resync = 1'b1; tick(); i_resync = 1'b0;
    put_k(); put_k(); put_k(); put_d(1'b0);
    put_k(); put_k(); put_k();
    check("krun_broken", 32'(o_state), 32'd0);
    put_k();
    check("krun_fourth", 32'(o_state), 32'd1);

    i_resync = 1'b1; tick(); i_resync = 1'b0;
    put_k(); put_k(); put(1'b0, 8'h55, 1'b0, 1'b0, 1'b0); put_k(); put_k();
    check("krun_gap", 32'(o_state), 32'd1);

    // In CS_CHECK with SYNC~ low, non-K chars are errors
    put_d(1'b0); put(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    check("chk_err2_state", 32'(o_state), 32'd1);
    put(1'b1, 8'hBC, 1'b1, 1'b1, 1'b0);
    check("chk_err3_state", 32'(o_state), 32'd0);

    // Asynchronous reset mid-CS_CHECK after SYNC~ release
    for (int i = 0; i < 4; i++) put_k();
    put(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("pre_rst_sync_n", 32'(o_sync_n), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(o_state), 32'd0);
    check("arst_sync_n", 32'(o_sync_n), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) put_k();
    check("post_rst_k3", 32'(o_state), 32'd0);
    put_k();
    check("post_rst_k4", 32'(o_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
